// File: rtl/wb_trace_pkg.sv
`default_nettype none
// ============================================================================
// wb_trace_pkg -- shared types for the writeback trace buffer
// Rev 1.0 -- initial release
// ============================================================================
package wb_trace_pkg;

    localparam logic [1:0] KIND_HALT   = 2'b00;
    localparam logic [1:0] KIND_REG    = 2'b01;
    localparam logic [1:0] KIND_MEM    = 2'b10;
    localparam logic [1:0] KIND_REGMEM = 2'b11;

    localparam int TS_W    = 16;
    localparam int ENTRY_W = 55;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [1:0]      kind;
        logic [4:0]      rd;
        logic [31:0]     data;
    } entry_t;

    // First readout beat of an entry: timestamp in the upper half, kind/rd at the bottom.
    function automatic logic [31:0] header_beat(input entry_t e);
        return {e.ts, 9'b0, e.kind, e.rd};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo -- show-ahead synchronous FIFO, simultaneous push/pop when full
// Rev 1.0 -- initial release
// ============================================================================
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // When full, the slot being written is the one being popped this edge.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// wb_trace_buffer -- captures pipeline writeback events into a FIFO, streams
// them out as two 32-bit beats. Define WB_TRACE_TIMESTAMP_EN for timestamps.
// Rev 1.0 -- initial release
// ============================================================================
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_en,
    input  logic [31:0] debug_alu_result,
    input  logic [4:0]  debug_reg_addr,
    input  logic        debug_reg_write,
    input  logic        debug_mem_write,
    input  logic        halt,
    output logic        trace_valid,
    output logic [31:0] trace_data,
    output logic        trace_last,
    input  logic        trace_ready,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        halted
);

    state_e            state_q, state_d;
    logic              beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic [TS_W-1:0]   ts_now;

    entry_t            ev;
    logic              ev_valid;
    logic              fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    entry_t            head;
    logic              xfer, pop, drop;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (state_q == ST_IDLE && trace_en) ts_d = '0;
        else if (state_q == ST_CAPTURE)     ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_d;
    end

    assign ts_now = ts_q;
`else
    assign ts_now = '0;
`endif

    // One event per capture cycle, highest priority first.
    always_comb begin
        ev       = '0;
        ev_valid = 1'b0;
        ev.ts    = ts_now;
        if (state_q == ST_CAPTURE) begin
            if (halt) begin
                ev_valid = 1'b1;
                ev.kind  = KIND_HALT;
                ev.data  = {16'h0000, ts_now};
            end else if (debug_reg_write && debug_reg_addr != 5'd0) begin
                ev_valid = 1'b1;
                ev.kind  = debug_mem_write ? KIND_REGMEM : KIND_REG;
                ev.rd    = debug_reg_addr;
                ev.data  = debug_alu_result;
            end else if (debug_mem_write) begin
                ev_valid = 1'b1;
                ev.kind  = KIND_MEM;
                ev.data  = debug_alu_result;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ev_valid),
        .wdata (ev),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head        = entry_t'(fifo_rdata);
    assign trace_valid = !fifo_empty;
    assign xfer        = trace_valid && trace_ready;
    assign pop         = xfer && beat_q;
    assign drop        = ev_valid && fifo_full && !pop;
    assign trace_last  = trace_valid && beat_q;
    assign trace_data  = !trace_valid ? 32'h0 : (beat_q ? head.data : header_beat(head));
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign halted      = (state_q == ST_HALTED);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        case (state_q)
            ST_IDLE:    if (trace_en) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!trace_en) state_d = ST_IDLE;
                else if (halt) state_d = ST_HALTED;
            end
            ST_HALTED:  if (!trace_en) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (xfer) beat_d = !beat_q;

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_wb_trace_buffer -- directed stimulus with a queue-based reference model
// Rev 1.0 -- initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam logic TS_ON = 1'b1;
`else
    localparam logic TS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic [31:0] debug_alu_result;
    logic [4:0]  debug_reg_addr;
    logic        debug_reg_write;
    logic        debug_mem_write;
    logic        halt;
    logic        trace_valid;
    logic [31:0] trace_data;
    logic        trace_last;
    logic        trace_ready;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trace_en         (trace_en),
        .debug_alu_result (debug_alu_result),
        .debug_reg_addr   (debug_reg_addr),
        .debug_reg_write  (debug_reg_write),
        .debug_mem_write  (debug_mem_write),
        .halt             (halt),
        .trace_valid      (trace_valid),
        .trace_data       (trace_data),
        .trace_last       (trace_last),
        .trace_ready      (trace_ready),
        .overflow         (overflow),
        .drop_count       (drop_count),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: the trace as two queues of beats, plus mode/timestamp/drop bookkeeping.
    logic [31:0] m_hdr[$];
    logic [31:0] m_dat[$];
    int          m_mode;   // 0 idle, 1 capture, 2 halted
    int          m_ts;
    bit          m_beat;
    bit          m_ovf;
    int          m_drops;

    always @(posedge clk or negedge rst_n) begin : model
        bit          have;
        int          kind;
        int          rd;
        logic [31:0] dat;
        int          tsf;
        if (!rst_n) begin
            m_hdr.delete();
            m_dat.delete();
            m_mode  = 0;
            m_ts    = 0;
            m_beat  = 0;
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            have = 0; kind = 0; rd = 0; dat = 0;
            tsf  = TS_ON ? m_ts : 0;
            if (m_mode == 1) begin
                if (halt) begin
                    have = 1; kind = 0; dat = tsf;
                end else if (debug_reg_write && debug_reg_addr != 0) begin
                    have = 1; kind = debug_mem_write ? 3 : 1;
                    rd = debug_reg_addr; dat = debug_alu_result;
                end else if (debug_mem_write) begin
                    have = 1; kind = 2; dat = debug_alu_result;
                end
            end
            if (m_hdr.size() > 0 && trace_ready) begin
                if (m_beat) begin
                    void'(m_hdr.pop_front());
                    void'(m_dat.pop_front());
                end
                m_beat = !m_beat;
            end
            if (have) begin
                if (m_hdr.size() < DEPTH) begin
                    m_hdr.push_back(tsf * 65536 + kind * 32 + rd);
                    m_dat.push_back(dat);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            case (m_mode)
                0: if (trace_en) begin m_mode = 1; m_ts = 0; end
                1: begin
                    m_ts = (m_ts + 1) % 65536;
                    if (!trace_en) m_mode = 0;
                    else if (halt) m_mode = 2;
                end
                default: if (!trace_en) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic        ev;
        logic [31:0] ed;
        if (rst_n) begin
            ev = (m_hdr.size() > 0);
            ed = 32'h0;
            if (ev) ed = m_beat ? m_dat[0] : m_hdr[0];
            chk("cyc_valid",  {31'b0, trace_valid}, {31'b0, ev});
            chk("cyc_data",   trace_data, ed);
            chk("cyc_last",   {31'b0, trace_last}, {31'b0, ev && m_beat});
            chk("cyc_ovf",    {31'b0, overflow}, {31'b0, m_ovf});
            chk("cyc_drops",  {24'b0, drop_count}, m_drops);
            chk("cyc_halted", {31'b0, halted}, {31'b0, m_mode == 2});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev;
        debug_reg_write  = 0;
        debug_mem_write  = 0;
        halt             = 0;
        debug_reg_addr   = 0;
        debug_alu_result = 0;
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d, input logic mw);
        debug_reg_write  = 1;
        debug_reg_addr   = a;
        debug_alu_result = d;
        debug_mem_write  = mw;
    endtask

    logic [31:0] got[$];
    int          n;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; trace_en = 0; trace_ready = 0;
        clr_ev();
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk("rst_valid",  {31'b0, trace_valid}, 0);
        chk("rst_data",   trace_data, 0);
        chk("rst_drops",  {24'b0, drop_count}, 0);
        chk("rst_halted", {31'b0, halted}, 0);

        // Single register write at ts 3
        trace_ready = 1; trace_en = 1;
        tick();
        repeat (3) tick();
        reg_wr(5'd10, 32'h0001_0000, 0);
        tick();
        clr_ev();
        chk("a_beat0", trace_data, TS_ON ? 32'h0003_002A : 32'h0000_002A);
        chk("a_last0", {31'b0, trace_last}, 0);
        tick();
        chk("a_beat1", trace_data, 32'h0001_0000);
        chk("a_last1", {31'b0, trace_last}, 1);
        tick();
        chk("a_empty", {31'b0, trace_valid}, 0);

        // x0 write alone is dropped silently; reg+mem collapses to one entry
        reg_wr(5'd0, 32'h1234_5678, 0);
        tick();
        clr_ev();
        tick();
        chk("b_x0", {31'b0, trace_valid}, 0);
        reg_wr(5'd5, 32'hDEAD_BEEF, 1);
        tick();
        clr_ev();
        chk("b_rm_hdr", {16'h0, trace_data[15:0]}, 32'h0000_0065);
        tick();
        chk("b_rm_dat", trace_data, 32'hDEAD_BEEF);
        tick();
        chk("b_single", {31'b0, trace_valid}, 0);
        debug_mem_write = 1; debug_alu_result = 32'h0000_0BAD;
        tick();
        clr_ev();
        chk("b_mem_hdr", {16'h0, trace_data[15:0]}, 32'h0000_0040);
        repeat (2) tick();
        chk("b_ovf0", {31'b0, overflow}, 0);

        // Overflow: DEPTH+3 writes with the reader stalled
        trace_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            reg_wr(5'((i % 30) + 1), 32'h100 + i, 0);
            tick();
        end
        clr_ev();
        chk("c_ovf",   {31'b0, overflow}, 1);
        chk("c_drops", {24'b0, drop_count}, 3);
        chk("c_hold",  {31'b0, trace_last}, 0);

        // Full FIFO: pop and push on the same edge
        trace_ready = 1;
        tick();
        reg_wr(5'd3, 32'hABCD_0123, 0);
        tick();
        clr_ev();
        chk("d_drops", {24'b0, drop_count}, 3);
        got.delete();
        n = 0;
        while (trace_valid && n < 4 * DEPTH) begin
            if (trace_last) got.push_back(trace_data);
            tick();
            n++;
        end
        chk("d_drained", {31'b0, trace_valid}, 0);
        chk("d_count", got.size(), DEPTH);
        if (got.size() == DEPTH) begin
            chk("d_first", got[0], 32'h101);
            chk("d_mid",   got[DEPTH-2], 32'h100 + DEPTH - 1);
            chk("d_new",   got[DEPTH-1], 32'hABCD_0123);
        end

        // Halt: ignored in idle, recorded at ts 0x20 in capture
        trace_en = 0;
        tick();
        halt = 1;
        tick();
        halt = 0;
        chk("e_idle_halt", {31'b0, halted}, 0);
        trace_en = 1;
        tick();
        repeat (32) tick();
        halt = 1;
        tick();
        halt = 0;
        chk("e_halted", {31'b0, halted}, 1);
        chk("e_hdr", trace_data, TS_ON ? 32'h0020_0000 : 32'h0);
        tick();
        chk("e_dat", trace_data, TS_ON ? 32'h0000_0020 : 32'h0);
        tick();
        reg_wr(5'd4, 32'h1, 1);
        tick();
        clr_ev();
        tick();
        chk("e_ignored", {31'b0, trace_valid}, 0);

        // Reset while beat0 is held
        trace_en = 0;
        tick();
        trace_ready = 0; trace_en = 1;
        tick();
        reg_wr(5'd9, 32'h99, 0);
        tick();
        clr_ev();
        chk("f_pre_valid", {31'b0, trace_valid}, 1);
        chk("f_pre_drops", {24'b0, drop_count}, 3);
        #2;
        rst_n = 0; trace_en = 0;
        #1;
        chk("f_valid", {31'b0, trace_valid}, 0);
        chk("f_data",  trace_data, 0);
        chk("f_last",  {31'b0, trace_last}, 0);
        chk("f_ovf",   {31'b0, overflow}, 0);
        chk("f_drops", {24'b0, drop_count}, 0);
        chk("f_halt",  {31'b0, halted}, 0);
        tick();
        rst_n = 1;
        tick();
        trace_en = 1;
        tick();
        reg_wr(5'd7, 32'h77, 0);
        tick();
        clr_ev();
        chk("f_new_hdr",  trace_data, 32'h0000_0027);
        chk("f_new_last", {31'b0, trace_last}, 0);
        trace_ready = 1;
        repeat (3) tick();
        chk("f_end", {31'b0, trace_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: trace_en  in  1  arm capture.
REQ-005 SHALL have ports: debug_alu_result  in  32  writeback/store value from pipeline debug port.
REQ-006 SHALL have ports: debug_reg_addr  in  5  destination register.
REQ-007 SHALL have ports: debug_reg_write  in  1  register write this cycle.
REQ-008 SHALL have ports: debug_mem_write  in  1  memory write this cycle.
REQ-009 SHALL have ports: halt  in  1  one-cycle pulse, ECALL retired.
REQ-010 SHALL have ports: trace_valid  out  1; trace_data  out  32; trace_last  out  1; trace_ready  in  1  readout stream.
REQ-011 SHALL have ports: overflow  out  1  sticky drop flag; drop_count  out  8  saturating dropped-event count; halted  out  1.

Function
REQ-012 States: IDLE, CAPTURE, HALTED; IDLE->CAPTURE when trace_en=1; CAPTURE->HALTED on halt; CAPTURE/HALTED->IDLE when trace_en=0.
REQ-013 In CAPTURE only, per cycle exactly one event: halt -> kind 00, data = timestamp; else reg_write && addr!=0 && mem_write -> kind 11, data = alu_result; else reg_write && addr!=0 -> kind 01; else mem_write -> kind 10, rd=0; writes to x0 alone SHALL not record.
REQ-014 Entry = {ts[15:0], kind[1:0], rd[4:0], data[31:0]}; pushed at edge N, trace_valid SHALL be assertable no earlier than edge N+1.
REQ-015 Readout: two beats per entry; beat0 = {ts[15:0], 9'b0, kind[1:0], rd[4:0]}, trace_last=0; beat1 = data, trace_last=1; entry popped on beat1 accept.
REQ-016 Beat transfers when trace_valid && trace_ready; trace_data/trace_last SHALL hold stable while trace_valid && !trace_ready.
REQ-017 Push accepted if FIFO not full or a pop occurs same edge; otherwise event dropped, overflow set, drop_count += 1 saturating at 255.
REQ-018 Timestamp: 16-bit counter cleared on IDLE->CAPTURE, +1 per cycle in CAPTURE, frozen in HALTED/IDLE, wraps 0xFFFF->0x0000.
REQ-019 FIFO contents and readout SHALL persist across HALTED->IDLE; draining continues in any state.
REQ-020 halted = 1 exactly in HALTED; halt outside CAPTURE ignored.

Reset
REQ-021 rst_n low SHALL immediately force: IDLE, FIFO empty, trace_valid=0, trace_data=0, trace_last=0, overflow=0, drop_count=0, halted=0, timestamp=0, beat pointer=beat0.
REQ-022 Reset mid-beat SHALL discard the partial entry; first beat after reset is beat0.

Configuration
REQ-023 Macro WB_TRACE_TIMESTAMP_EN: defined -> timestamp counter per REQ-018; undefined -> no counter, ts field and halt data SHALL be 0.

Structure
REQ-024 Package wb_trace_pkg SHALL hold kind encodings (KIND_HALT=00, KIND_REG=01, KIND_MEM=10, KIND_REGMEM=11), state enum, entry struct/width constant.
REQ-025 Sub-module trace_fifo (synchronous, DEPTH x 55 bits, full/empty, simultaneous push/pop) SHALL hold storage.

Verification
REQ-026 trace_en=1, reg write x10=0x00010000 at ts 3, ready=1 -> beats 0x00030000|01<<5|10 = 0x0003002A, then 0x00010000 with trace_last=1.
REQ-027 reg_write addr=0 only -> no entry; reg_write x5 + mem_write same cycle -> single kind 11 entry, rd=5.
REQ-028 ready=0, DEPTH+3 reg writes -> DEPTH entries retained, overflow=1, drop_count=3; then ready=1 drains in order.
REQ-029 Full FIFO, pop and new event same edge -> event accepted, drop_count unchanged.
REQ-030 halt at ts 0x0020 -> kind 00 entry data 0x00000020, halted=1, subsequent writes ignored; with WB_TRACE_TIMESTAMP_EN undefined ts/data = 0.
REQ-031 rst_n low while beat0 held with ready=0 -> all outputs 0 immediately; after release, new capture starts at beat0, ts=0.
